// File: rtl/uart_rx_frame_buffer.sv
// Receive-side frame buffer behind the UART Rx controller: captures finished frames with
// their parity/framing status, queues them in a small FWFT FIFO and keeps error statistics.
module uart_rx_frame_buffer #(
    parameter int data_size      = 8,
    parameter int fifo_depth     = 4,
    parameter int ptr_width      = 2,
    parameter bit drop_on_error  = 1'b1,
    parameter int err_cntr_width = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [data_size-1:0]      Rx_reg,
    input  logic                      data_err_en,
    input  logic                      data_error,
    input  logic                      frame_done,
    input  logic                      trans_error,
    input  logic                      rd_ready,
    input  logic                      cntr_clr,
    output logic                      rd_valid,
    output logic [data_size-1:0]      rd_data,
    output logic [1:0]                rd_status,
    output logic [ptr_width:0]        fifo_count,
    output logic                      overrun,
    output logic [err_cntr_width-1:0] frm_err_cnt,
    output logic [err_cntr_width-1:0] par_err_cnt,
    output logic [err_cntr_width-1:0] ovr_cnt
);

    localparam int ENTRY_W = data_size + 2;
    localparam logic [ptr_width:0] FULL_COUNT = (ptr_width + 1)'(fifo_depth);

    logic [ENTRY_W-1:0]        mem [fifo_depth];
    logic [ptr_width-1:0]      wr_ptr;
    logic [ptr_width-1:0]      rd_ptr;
    logic [ptr_width:0]        count;
    logic                      par_q;

    logic                      par_eff;
    logic                      errored;
    logic                      want_push;
    logic                      push;
    logic                      pop;
    logic                      lost;
    logic [ENTRY_W-1:0]        entry;

    // Parity strobe arriving in the same cycle as frame_done is used directly.
    assign par_eff   = data_err_en ? data_error : par_q;
    assign errored   = par_eff | trans_error;
    assign entry     = {par_eff, trans_error, Rx_reg};

    // Read port handshake: rd_valid means the head entry is present and stable; the entry is
    // consumed on any cycle where rd_valid && rd_ready, and rd_ready alone has no effect.
    assign rd_valid  = (count != '0);
    assign pop       = rd_valid && rd_ready;

    assign want_push = frame_done && !(drop_on_error && errored);
    assign push      = want_push && ((count < FULL_COUNT) || pop);
    assign lost      = want_push && !push;

    assign rd_data    = mem[rd_ptr][data_size-1:0];
    assign rd_status  = mem[rd_ptr][ENTRY_W-1:data_size];
    assign fifo_count = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else if (frame_done) begin
            par_q <= 1'b0;
        end else if (data_err_en) begin
            par_q <= data_error;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < fifo_depth; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // A clear wins over any increment landing in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun     <= 1'b0;
            frm_err_cnt <= '0;
            par_err_cnt <= '0;
            ovr_cnt     <= '0;
        end else if (cntr_clr) begin
            overrun     <= 1'b0;
            frm_err_cnt <= '0;
            par_err_cnt <= '0;
            ovr_cnt     <= '0;
        end else begin
            if (lost) begin
                overrun <= 1'b1;
            end
            if (frame_done && trans_error && (frm_err_cnt != '1)) begin
                frm_err_cnt <= frm_err_cnt + 1'b1;
            end
            if (frame_done && par_eff && (par_err_cnt != '1)) begin
                par_err_cnt <= par_err_cnt + 1'b1;
            end
            if (lost && (ovr_cnt != '1)) begin
                ovr_cnt <= ovr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_buffer.sv
// Directed bench for uart_rx_frame_buffer: one instance drops errored frames, a second
// instance queues them so their status bits can be checked.
module tb_uart_rx_frame_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] Rx_reg = '0;
    logic       data_err_en = 1'b0;
    logic       data_error = 1'b0;
    logic       frame_done = 1'b0;
    logic       trans_error = 1'b0;
    logic       rd_ready = 1'b0;
    logic       cntr_clr = 1'b0;

    logic       rd_valid, nd_rd_valid;
    logic [7:0] rd_data, nd_rd_data;
    logic [1:0] rd_status, nd_rd_status;
    logic [2:0] fifo_count, nd_fifo_count;
    logic       overrun, nd_overrun;
    logic [7:0] frm_err_cnt, nd_frm_err_cnt;
    logic [7:0] par_err_cnt, nd_par_err_cnt;
    logic [7:0] ovr_cnt, nd_ovr_cnt;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    uart_rx_frame_buffer #(.drop_on_error(1'b1)) dut (
        .clk(clk), .rst(rst), .Rx_reg(Rx_reg), .data_err_en(data_err_en),
        .data_error(data_error), .frame_done(frame_done), .trans_error(trans_error),
        .rd_ready(rd_ready), .cntr_clr(cntr_clr), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_status(rd_status), .fifo_count(fifo_count), .overrun(overrun),
        .frm_err_cnt(frm_err_cnt), .par_err_cnt(par_err_cnt), .ovr_cnt(ovr_cnt)
    );

    uart_rx_frame_buffer #(.drop_on_error(1'b0)) dut_nd (
        .clk(clk), .rst(rst), .Rx_reg(Rx_reg), .data_err_en(data_err_en),
        .data_error(data_error), .frame_done(frame_done), .trans_error(trans_error),
        .rd_ready(rd_ready), .cntr_clr(cntr_clr), .rd_valid(nd_rd_valid), .rd_data(nd_rd_data),
        .rd_status(nd_rd_status), .fifo_count(nd_fifo_count), .overrun(nd_overrun),
        .frm_err_cnt(nd_frm_err_cnt), .par_err_cnt(nd_par_err_cnt), .ovr_cnt(nd_ovr_cnt)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic te);
        Rx_reg      = d;
        trans_error = te;
        frame_done  = 1'b1;
        tick();
        frame_done  = 1'b0;
        trans_error = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic drain_dut(input string tag);
        logic [7:0] want;
        while (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check({tag, "_valid"}, 32'(rd_valid), 32'd1);
            check({tag, "_data"}, 32'(rd_data), 32'(want));
            rd_ready = 1'b1;
            tick();
        end
        rd_ready = 1'b0;
        check({tag, "_empty"}, 32'(rd_valid), 32'd0);
    endtask

    initial begin
        apply_reset();
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_cnts", {8'(0), frm_err_cnt, par_err_cnt, ovr_cnt}, 32'd0);

        // 1: three clean frames, then in-order read
        send_frame(8'hA5, 1'b0);
        check("t1_latency", 32'(rd_valid), 32'd1);
        send_frame(8'h3C, 1'b0);
        send_frame(8'hFF, 1'b0);
        exp_q = '{8'hA5, 8'h3C, 8'hFF};
        check("t1_count", 32'(fifo_count), 32'd3);
        check("t1_head", 32'(rd_data), 32'hA5);
        tick();
        check("t1_hold", 32'(rd_data), 32'hA5);
        drain_dut("t1");
        check("t1_cnts", {8'(0), frm_err_cnt, par_err_cnt, ovr_cnt}, 32'd0);
        check("t1_nd_count", 32'(nd_fifo_count), 32'd0);

        // 2: errored frames dropped vs. queued with status
        send_frame(8'h11, 1'b1);
        check("t2_frm_drop_count", 32'(fifo_count), 32'd0);
        check("t2_frm_cnt", 32'(frm_err_cnt), 32'd1);
        check("t2_nd_head", 32'(nd_rd_data), 32'h11);
        check("t2_nd_status_frm", 32'(nd_rd_status), 32'b01);
        data_err_en = 1'b1;
        data_error  = 1'b1;
        tick();
        data_err_en = 1'b0;
        data_error  = 1'b0;
        tick();
        send_frame(8'h22, 1'b0);
        check("t2_par_drop_count", 32'(fifo_count), 32'd0);
        check("t2_par_cnt", 32'(par_err_cnt), 32'd1);
        check("t2_frm_cnt_keep", 32'(frm_err_cnt), 32'd1);
        check("t2_nd_count", 32'(nd_fifo_count), 32'd2);
        send_frame(8'h33, 1'b0);
        check("t2_clean_count", 32'(fifo_count), 32'd1);
        check("t2_par_cleared", 32'(rd_status), 32'b00);
        check("t2_par_cnt_keep", 32'(par_err_cnt), 32'd1);
        rd_ready = 1'b1;
        tick();
        check("t2_nd_head2", 32'(nd_rd_data), 32'h22);
        check("t2_nd_status_par", 32'(nd_rd_status), 32'b10);
        tick();
        check("t2_ready_no_valid", 32'(fifo_count), 32'd0);
        check("t2_nd_head3", 32'(nd_rd_data), 32'h33);
        check("t2_nd_status_clean", 32'(nd_rd_status), 32'b00);
        tick();
        rd_ready = 1'b0;
        check("t2_nd_empty", 32'(nd_rd_valid), 32'd0);

        // 3: overrun when full, push+pop when full
        for (int i = 0; i < 4; i++) send_frame(8'(8'h40 + i), 1'b0);
        check("t3_full", 32'(fifo_count), 32'd4);
        check("t3_no_ovr", 32'(overrun), 32'd0);
        send_frame(8'h44, 1'b0);
        check("t3_ovr_count", 32'(fifo_count), 32'd4);
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_ovr_cnt", 32'(ovr_cnt), 32'd1);
        check("t3_head_kept", 32'(rd_data), 32'h40);
        rd_ready = 1'b1;
        send_frame(8'h45, 1'b0);
        rd_ready = 1'b0;
        check("t3_pushpop_count", 32'(fifo_count), 32'd4);
        check("t3_pushpop_ovr_cnt", 32'(ovr_cnt), 32'd1);
        check("t3_pushpop_overrun", 32'(overrun), 32'd1);
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h45};
        drain_dut("t3");

        // 4: counter saturation and clear priority
        frame_done  = 1'b1;
        trans_error = 1'b1;
        for (int i = 0; i < 300; i++) begin
            Rx_reg = 8'(i);
            tick();
        end
        check("t4_sat", 32'(frm_err_cnt), 32'd255);
        cntr_clr = 1'b1;
        tick();
        cntr_clr    = 1'b0;
        frame_done  = 1'b0;
        trans_error = 1'b0;
        check("t4_clr_frm", 32'(frm_err_cnt), 32'd0);
        check("t4_clr_other", {16'(0), par_err_cnt, ovr_cnt}, 32'd0);
        check("t4_clr_overrun", 32'(overrun), 32'd0);
        send_frame(8'h77, 1'b1);
        check("t4_after_clr", 32'(frm_err_cnt), 32'd1);
        check("t4_fifo_untouched", 32'(fifo_count), 32'd0);

        // 5: asynchronous reset with entries queued
        apply_reset();
        for (int i = 0; i < 5; i++) send_frame(8'(8'h50 + i), 1'b0);
        rd_ready = 1'b1;
        repeat (2) tick();
        rd_ready = 1'b0;
        check("t5_pre_count", 32'(fifo_count), 32'd2);
        check("t5_pre_overrun", 32'(overrun), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t5_async_valid", 32'(rd_valid), 32'd0);
        check("t5_async_count", 32'(fifo_count), 32'd0);
        check("t5_async_overrun", 32'(overrun), 32'd0);
        #1 rst = 1'b1;
        tick();
        send_frame(8'h5A, 1'b0);
        check("t5_new_head", 32'(rd_data), 32'h5A);
        check("t5_new_count", 32'(fifo_count), 32'd1);
        check("t5_new_status", 32'(rd_status), 32'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
